// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by fetch_buf and inst_fetch; no build macros.
package fetch_pkg;

  localparam int INST_W          = 32;
  localparam int PC_W            = 32;
  localparam int FETCH_BUF_DEPTH = 2;
  // Occupancy counter width, sized to hold 0..FETCH_BUF_DEPTH.
  localparam int CNT_W           = $clog2(FETCH_BUF_DEPTH + 1);

  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0000;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [INST_W-1:0] instr;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  // Value held by an empty / flushed slot.
  localparam fetch_entry_t FETCH_ENTRY_NULL = '{instr: INST_NOP, pc: '0};

endpackage

// File: rtl/fetch_buf.sv
// Small shift-style FIFO of fetch_entry_t between memory return and decode.
// Slot 0 is always the head and is a plain register, so a push becomes
// visible on o_head the cycle after it is written. Push and pop in the same
// cycle are both performed; flush empties and zeroes every slot.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  fetch_entry_t     i_push_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output fetch_entry_t     o_head
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FETCH_BUF_DEPTH);

  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_wr_idx;

  // A pop only happens on a non-empty buffer; the write slot is the first
  // free slot after the pop has shifted everything down by one.
  always_comb begin
    w_pop    = i_pop && (r_count != '0);
    w_wr_idx = r_count - CNT_W'(w_pop);
    w_push   = i_push && (w_wr_idx < DEPTH_CNT);
  end

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_BUF_DEPTH; gi++) begin : g_entry
      fetch_entry_t r_entry;
      fetch_entry_t w_entry_next;
      fetch_entry_t w_shift_in;

      // Entry that moves into this slot when the head is popped.
      if (gi + 1 < FETCH_BUF_DEPTH) begin : g_shift
        assign w_shift_in = g_entry[gi+1].r_entry;
      end else begin : g_last
        assign w_shift_in = r_entry;
      end

      // Slot update: flush, then a push landing here, then a pop shift.
      always_comb begin
        w_entry_next = r_entry;
        if (i_flush) begin
          w_entry_next = FETCH_ENTRY_NULL;
        end else if (w_push && (w_wr_idx == CNT_W'(gi))) begin
          w_entry_next = i_push_entry;
        end else if (w_pop) begin
          w_entry_next = w_shift_in;
        end
      end

      // Slot register; reset clears it so the head reads as zero.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_entry <= FETCH_ENTRY_NULL;
        end else begin
          r_entry <= w_entry_next;
        end
      end
    end
  endgenerate

  // Occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = g_entry[0].r_entry;

endmodule

// File: rtl/inst_fetch.sv
// PC generation and fetch stage in front of a 1-cycle registered-read
// instruction memory. Reads are issued only when the buffer is guaranteed
// to have room for their data (credit = buffered + in flight - leaving),
// so decode stalls never drop or duplicate an instruction.
// Build macro INST_FETCH_FAST_REDIRECT_EN: when defined, a redirect target
// is sent to memory in the redirect cycle itself instead of one cycle later.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [31:0]       id_pc
);

  logic [PC_W-1:0]  r_pc;
  logic             r_req_vld;
  logic [PC_W-1:0]  r_req_pc;

  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;
  logic             w_deq;
  logic             w_push;
  logic [2:0]       w_inflight;
  logic             w_issue;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_fetch_pc;

  assign w_target = {redirect_pc[31:2], 2'b00};
  assign w_deq    = id_valid && id_ready;

  // Slots that will be occupied after this cycle's dequeue, counting the
  // read whose data is arriving now. deq implies count >= 1, so no underflow.
  assign w_inflight = 3'(w_count) + 3'(r_req_vld) - 3'(w_deq);

`ifdef INST_FETCH_FAST_REDIRECT_EN
  // The redirect target goes to memory immediately; the buffer is flushed
  // this cycle, so the credit check is trivially satisfied.
  always_comb begin
    w_fetch_pc = redirect_valid ? w_target : r_pc;
    w_issue    = redirect_valid || (w_inflight < 3'd2);
  end
`else
  // The redirect cycle issues nothing; the target is fetched next cycle.
  always_comb begin
    w_fetch_pc = r_pc;
    w_issue    = !redirect_valid && (w_inflight < 3'd2);
  end
`endif

  assign imem_addr = w_fetch_pc[ADDR_W+1:2];

  // PC and outstanding-read tracking; a redirect that does not issue just
  // loads the target for the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_req_vld <= 1'b0;
      r_req_pc  <= '0;
    end else if (w_issue) begin
      r_pc      <= w_fetch_pc + 32'd4;
      r_req_vld <= 1'b1;
      r_req_pc  <= w_fetch_pc;
    end else begin
      r_req_vld <= 1'b0;
      if (redirect_valid) begin
        r_pc <= w_target;
      end
    end
  end

  // Returning read data is dropped when a redirect makes it stale.
  assign w_push       = r_req_vld && !redirect_valid;
  assign w_push_entry = '{instr: INST_W'(imem_data), pc: r_req_pc};

  fetch_buf u_buf (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_deq),
    .i_flush      (redirect_valid),
    .o_count      (w_count),
    .o_head       (w_head)
  );

  assign id_valid = (w_count != '0);
  assign id_instr = DATA_W'(w_head.instr);
  assign id_pc    = w_head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch. The reference model tracks the
// architectural instruction stream: after a reset or redirect, decode must
// see consecutive PCs starting at the restart address, each paired with the
// memory word at that address, with fixed restart latency and no gaps.
module tb_inst_fetch;

  localparam int          ADDR_W   = 10;
  localparam int          DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef INST_FETCH_FAST_REDIRECT_EN
  localparam int REDIR_LAT = 2;
  localparam bit FAST      = 1'b1;
`else
  localparam int REDIR_LAT = 3;
  localparam bit FAST      = 1'b0;
`endif
  localparam int RESET_LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data = '0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              id_valid;
  logic              id_ready = 1'b0;
  logic [DATA_W-1:0] id_instr;
  logic [31:0]       id_pc;

  inst_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  // 1K x 32 instruction memory with a registered read.
  logic [31:0] mem [1024];
  always @(posedge clk) imem_data <= mem[imem_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Reference-model state.
  bit          armed = 1'b0;
  bit          last_rst = 1'b0;
  int          k = 0;
  int          lat = RESET_LAT;
  logic [31:0] exp_pc = RESET_PC;
  int          stall_run = 0;
  logic [31:0] prev_pc, prev_instr;
  logic [ADDR_W-1:0] prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs, advance the model.
  task automatic step(input bit r, input bit rv, input logic [31:0] rp, input bit rd);
    logic [31:0] exp_instr;
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    id_ready       = rd;
    #1;
    cycle++;
    if (armed) begin
      chk("count_le2", 32'(dut.w_count <= 2'd2), 32'd1);
      if (k == 1 && last_rst) begin
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
      end
      chk("valid", 32'(id_valid), 32'(k >= lat));
      if (stall_run >= 1) begin
        chk("stall_pc", id_pc, prev_pc);
        chk("stall_instr", id_instr, prev_instr);
      end
      if (stall_run >= 2 && !r && !rv) begin
        chk("stall_count", 32'(dut.w_count), 32'd2);
        chk("stall_addr", 32'(imem_addr), 32'(prev_addr));
      end
      if (FAST && rv && !r) chk("fast_addr", 32'(imem_addr), 32'(rp[ADDR_W+1:2]));
      if (k >= lat && id_valid && rd) begin
        exp_instr = mem[exp_pc[ADDR_W+1:2]];
        chk("deq_pc", id_pc, exp_pc);
        chk("deq_instr", id_instr, exp_instr);
        $display("[TB] cyc %0d deq pc=%h instr=%h", cycle, id_pc, id_instr);
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (armed && k >= lat && id_valid && !rd && !r && !rv) stall_run++;
    else stall_run = 0;
    prev_pc    = id_pc;
    prev_instr = id_instr;
    prev_addr  = imem_addr;
    if (r) begin
      armed = 1'b1; last_rst = 1'b1; k = 0; lat = RESET_LAT; exp_pc = RESET_PC;
    end else if (rv && armed) begin
      last_rst = 1'b0; k = 0; lat = REDIR_LAT; exp_pc = {rp[31:2], 2'b00};
    end
    if (armed && k < 100000) k++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;

    // Reset, then stream.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    // Decode stall of 5 cycles, then resume.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    // Redirect to 0x103 while two entries are buffered.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0103, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    // Redirect in the same cycle as a dequeue.
    step(0, 1, 32'h0000_0200, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    // One-cycle reset mid-stream.
    step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    // Wrap of the memory word address at the 4 KB boundary.
    step(0, 1, 32'h0000_0FFC, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    // Wrap of the 32-bit PC.
    step(0, 1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    // Redirect and reset together: reset wins.
    step(1, 1, 32'h0000_0400, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit          r, rv, rd;
      logic [31:0] rp;
      rd = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 99) == 0);
      rp = $urandom;
      step(r, rv, rp, rd);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- PC-generation and fetch stage that sits directly upstream of the 1K x 32 instruction memory.
- Drives the memory read address and absorbs its 1-cycle registered read latency.
- Hands {instr, pc} to decode over a valid/ready handshake.
- Holds a 2-entry buffer and issues reads by credit, so decode stalls never lose or duplicate an instruction; branch/jump redirects flush all in-flight work.

Parameters:
- ADDR_W, 10, instruction-memory word-address width (1K words).
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- imem_addr  output  ADDR_W  word read address to instruction memory; equals pc_q[ADDR_W+1:2].
- imem_data  input  DATA_W  memory read data, valid one cycle after the address was presented.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_pc  input  32  redirect target, byte address; bits [1:0] are ignored and treated as 0.
- id_valid  output  1  buffer head holds an instruction.
- id_ready  input  1  decode accepts the head this cycle.
- id_instr  output  DATA_W  instruction at the buffer head.
- id_pc  output  32  byte PC of id_instr.

Behaviour:
- State:
  - pc_q: next fetch address.
  - req_vld_q / req_pc_q: a read issued last cycle, whose data is on imem_data this cycle.
  - 2-entry FIFO of {instr, pc}; count is 0..2.
- Reset (rst=1 at posedge):
  - pc_q=RESET_PC, req_vld_q=0, FIFO emptied with entries zeroed.
  - Resulting outputs: id_valid=0, id_instr=0, id_pc=0.
  - Reset mid-operation discards everything, including in-flight reads.
- deq = id_valid & id_ready.
- issue = !redirect_valid & (count + req_vld_q - deq < 2).
- On issue: pc_q <= pc_q+4, req_vld_q <= 1, req_pc_q <= pc_q.
- Without issue: pc_q holds and req_vld_q <= 0.
- imem_addr is always driven; a read that is not issued is harmless and its data is ignored.
- When req_vld_q=1 and there is no redirect, {imem_data, req_pc_q} is pushed. The credit rule guarantees space, so overflow is impossible.
  - Verification asserts count<=2 and never push-when-full.
- FIFO head is registered: a push becomes visible on id_* the following cycle. Push and pop in the same cycle are both performed.
- Latency: first cycle with rst=0 is cycle 0; RESET_PC is issued in cycle 0 and id_valid rises in cycle 2.
- Throughput: with id_ready held high, one instruction per cycle sustained.
- Stall: while id_ready=0, id_valid/id_instr/id_pc stay stable; at most 2 instructions are buffered and issue stops.
- Redirect (redirect_valid=1 in cycle t):
  - FIFO cleared and the push of imem_data suppressed.
  - req_vld_q <= 0; pc_q <= {redirect_pc[31:2], 2'b00}.
  - id_valid=0 in cycle t+1.
  - Redirect has priority over push/issue. A deq in cycle t still counts as accepted by decode.
- Wrap-around: pc_q wraps modulo 2^32; imem_addr wraps naturally every 4 KB.
- Simultaneous redirect and rst: rst wins.

Optional Feature:
- Macro: INST_FETCH_FAST_REDIRECT_EN.
- Defined:
  - In the redirect cycle, imem_addr = redirect_pc[ADDR_W+1:2] and the target is issued that same cycle.
  - pc_q <= target+4, req_vld_q <= 1, req_pc_q <= target.
  - Redirect-to-id_valid latency is 2 cycles.
- Undefined:
  - The target is issued in cycle t+1 (one bubble cycle).
  - Redirect-to-id_valid latency is 3 cycles.

Decomposition:
- Package fetch_pkg holds:
  - INST_W=32, PC_W=32, FETCH_BUF_DEPTH=2.
  - INST_NOP=32'h0000_0000.
  - Typedef fetch_entry_t {instr, pc}.
- Sub-module fetch_buf: 2-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count and head outputs, and the same clk/rst.
- inst_fetch owns the PC, the credit logic and the redirect handling.

Test Plan:
- Reset then id_ready=1 with mem[i]=32'h1000_0000+i -> id_valid from cycle 2; pairs (32'h1000_0000, pc 0x0), (32'h1000_0001, pc 0x4), ... one per cycle with no gaps.
- Stream, then id_ready=0 for 5 cycles -> id_instr/id_pc frozen, count=2, imem issues stop; on release, the sequence resumes with no drop or duplicate.
- redirect_valid with redirect_pc=0x0000_0103 while 2 entries are buffered -> id_valid=0 next cycle; next delivered id_pc=0x100 at 3 cycles (2 with INST_FETCH_FAST_REDIRECT_EN); stale instructions never appear.
- redirect in the same cycle as deq with id_ready=1 -> the head counts as consumed once, everything else is flushed.
- rst asserted mid-stream for 1 cycle -> all outputs 0 the next cycle; the first id_pc after restart is RESET_PC.
- redirect_pc=0x0000_0FFC, stream 3 instructions -> id_pc 0xFFC, 0x1000, 0x1004 with imem_addr 1023, 0, 1.
